// File: rtl/dvi_pkg.sv
// Shared constants, types and helpers for the DVI TMDS transmitter.
package dvi_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 6;

  // Control-period symbols indexed by {c1,c0}
  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  // TMDS clock channel: five ones then five zeros, LSB first
  localparam logic [SYM_W-1:0] CLK_PATTERN = 10'b0000011111;

  // One captured pixel as delivered by the timing generator
  typedef struct packed {
    logic       blank;
    logic       v_sync;
    logic       h_sync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } video_t;

  localparam video_t VIDEO_RST = '{blank: 1'b1, default: '0};

  // Number of set bits in a byte (0..8)
  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Control symbol for a {c1,c0} pair
  function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
    logic [SYM_W-1:0] s;
    unique case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dvi_tmds_tx_encoder.sv
// TMDS 8b/10b encoder for one colour channel: transition-minimising stage
// (stage 1) followed by DC balancing against a running disparity (stage 2).
// Both stages fire once per pixel, one and two clk edges after the load strobe.
module tmds_channel_encoder
  import dvi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             blank,
  input  logic [1:0]       c,
  input  logic [7:0]       d,
  output logic [SYM_W-1:0] sym
);

  logic                    st1_q, st2_q;
  logic [8:0]              qm_q, qm_d;
  logic                    blank1_q;
  logic [1:0]              c1_q;
  logic [3:0]              n1_d;
  logic [3:0]              n1q;
  logic signed [CNT_W-1:0] n1s, disp;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0]        sym_q, sym_d;

  // Stage enables: the load strobe delayed by one and two edges
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st1_q <= 1'b0;
      st2_q <= 1'b0;
    end else begin
      st1_q <= ld;
      st2_q <= st1_q;
    end
  end

  // Stage 1: choose XOR or XNOR chain to minimise transitions
  always_comb begin
    logic [8:0] q;
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    q    = '0;
    n1_d = ones8(d);
    // NOTE: blocking (=) here is deliberate: each chain bit reads the bit
    // computed on the previous line within the same evaluation.
    q[0] = d[0];
    if (n1_d > 4'd4 || (n1_d == 4'd4 && !d[0])) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    qm_d = q;
  end

  // Stage 1 registers, carrying blank/control alongside the data
  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q     <= '0;
      blank1_q <= 1'b1;
      c1_q     <= 2'b00;
    end else if (st1_q) begin
      qm_q     <= qm_d;
      blank1_q <= blank;
      c1_q     <= c;
    end
  end

  // Stage 2: DC balance; disp = n1q - n0q = 2*n1q - 8
  always_comb begin
    n1q   = ones8(qm_q[7:0]);
    n1s   = signed'({2'b00, n1q});
    disp  = (n1s <<< 1) - 6'sd8;
    sym_d = sym_q;
    cnt_d = cnt_q;
    if (blank1_q) begin
      sym_d = ctrl_sym(c1_q);
      cnt_d = '0;
    end else if (cnt_q == '0 || disp == '0) begin
      sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt_q + disp) : (cnt_q - disp);
    end else if (cnt_q[CNT_W-1] == disp[CNT_W-1]) begin
      sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) - disp;
    end else begin
      sym_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt_q - (qm_q[8] ? 6'sd0 : 6'sd2) + disp;
    end
  end

  // Stage 2 registers: output symbol and running disparity
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= CTRL_00;
      cnt_q <= '0;
    end else if (st2_q) begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/dvi_tmds_tx.sv
// DVI/HDMI TMDS transmitter: captures one pixel per pixel_clk rising edge,
// encodes three colour channels and serialises each 10-bit symbol LSB-first.
// Optional clock channel serialiser enabled by defining DVI_TX_CLK_CH_EN;
// otherwise tmds_clk is tied low.
module dvi_tmds_tx
  import dvi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_clk,
  input  logic       blanking,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [2:0] tmds_d,
  output logic       tmds_clk
);

  logic                    pclk_q;
  logic                    ld;
  video_t                  vid_q;
  logic [SYM_W-1:0]        sym_b, sym_g, sym_r;
  logic [2:0][SYM_W-1:0]   sym_all;
  logic [2:0][SYM_W-1:0]   sh_q, sh_d;

  // Pixel strobe edge detector; ld marks the symbol frame boundary
  always_ff @(posedge clk) begin
    if (rst) pclk_q <= 1'b0;
    else     pclk_q <= pixel_clk;
  end

  assign ld = pixel_clk & ~pclk_q;

  // Stage 0: capture the pixel on the load edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_q <= VIDEO_RST;
    end else if (ld) begin
      vid_q <= '{blank: blanking, v_sync: v_sync, h_sync: h_sync,
                 red: red, green: green, blue: blue};
    end
  end

  // Blue carries the syncs during blanking; green and red carry 00
  tmds_channel_encoder u_enc_b (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .blank (vid_q.blank),
    .c     ({vid_q.v_sync, vid_q.h_sync}),
    .d     (vid_q.blue),
    .sym   (sym_b)
  );

  tmds_channel_encoder u_enc_g (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .blank (vid_q.blank),
    .c     (2'b00),
    .d     (vid_q.green),
    .sym   (sym_g)
  );

  tmds_channel_encoder u_enc_r (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .blank (vid_q.blank),
    .c     (2'b00),
    .d     (vid_q.red),
    .sym   (sym_r)
  );

  assign sym_all = {sym_r, sym_g, sym_b};

  // Serialiser next state: reload on ld (truncating any early frame),
  // otherwise shift right with zero fill (late frames emit zeros)
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < 3; i++) begin
      sh_d[i] = ld ? sym_all[i] : {1'b0, sh_q[i][SYM_W-1:1]};
    end
  end

  // Data serialiser registers
  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign tmds_d = {sh_q[2][0], sh_q[1][0], sh_q[0][0]};

`ifdef DVI_TX_CLK_CH_EN
  logic [SYM_W-1:0] ck_q, ck_d;

  // Clock channel next state, framed identically to the data lanes
  always_comb begin
    ck_d = ld ? CLK_PATTERN : {1'b0, ck_q[SYM_W-1:1]};
  end

  // Clock channel serialiser register
  always_ff @(posedge clk) begin
    if (rst) ck_q <= '0;
    else     ck_q <= ck_d;
  end

  assign tmds_clk = ck_q[0];
`else
  assign tmds_clk = 1'b0;
`endif

endmodule

// File: tb/tb_dvi_tmds_tx.sv
// Directed testbench for dvi_tmds_tx. Each task drives one scenario and
// checks the serial output against hand-derived TMDS symbols.
module tb_dvi_tmds_tx;

  logic       clk;
  logic       rst;
  logic       pixel_clk;
  logic       blanking;
  logic       h_sync;
  logic       v_sync;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [2:0] tmds_d;
  logic       tmds_clk;

  int total = 0;
  int bad   = 0;

  logic [2:0][15:0] cd;
  logic [15:0]      cc;

  localparam logic [9:0] S_C00 = 10'b1101010100;
  localparam logic [9:0] S_C01 = 10'b0010101011;
  localparam logic [9:0] S_C10 = 10'b0101010100;
  localparam logic [9:0] S_C11 = 10'b1010101011;

  dvi_tmds_tx dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_clk (pixel_clk),
    .blanking  (blanking),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .tmds_d    (tmds_d),
    .tmds_clk  (tmds_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial bits of symbol s over a frame of len cycles
  function automatic logic [15:0] exp_bits(input logic [9:0] s, input int len);
    logic [15:0] m;
    m = (16'd1 << len) - 16'd1;
    return {6'b000000, s} & m;
  endfunction

  function automatic logic [15:0] exp_clk(input int len);
    logic [15:0] e;
    e = exp_bits(10'b0000011111, len);
`ifndef DVI_TX_CLK_CH_EN
    e = '0;
`endif
    return e;
  endfunction

  // One pixel frame of len cycles (pixel_clk high 5, low len-5). Inputs are
  // presented for the ld edge at the start; captures the serial bits shown
  // during this frame, i.e. the symbol of the previously sent pixel.
  task automatic pixel(input int len, input logic bl, input logic hs,
                       input logic vs, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, output logic [2:0][15:0] d_o,
                       output logic [15:0] c_o);
    d_o = '0;
    c_o = '0;
    pixel_clk = 1'b1;
    blanking  = bl;
    h_sync    = hs;
    v_sync    = vs;
    red       = r;
    green     = g;
    blue      = b;
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) d_o[l][k] = tmds_d[l];
      c_o[k] = tmds_clk;
      if (k == 4) pixel_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pixel_clk = 1'b0; blanking = 1'b1;
    h_sync = 1'b0; v_sync = 1'b0; red = '0; green = '0; blue = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (tmds_d !== 3'b000 || tmds_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got d=%b clk=%b expected d=000 clk=0", tmds_d, tmds_clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (tmds_d !== 3'b000 || tmds_clk !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: got d=%b clk=%b expected d=000 clk=0", tmds_d, tmds_clk);
      end
    end
    // First ld releases the reset-value control symbol
    pixel(10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    for (int l = 0; l < 3; l++) begin
      total++;
      if (cd[l] !== exp_bits(S_C00, 10)) begin
        bad++;
        $display("FAIL first_ld lane%0d: got %b expected %b", l, cd[l], exp_bits(S_C00, 10));
      end
    end
    total++;
    if (cc !== exp_clk(10)) begin
      bad++;
      $display("FAIL first_ld_clk: got %b expected %b", cc, exp_clk(10));
    end
  endtask

  task automatic test_ctrl_idle();
    for (int p = 0; p < 3; p++) begin
      pixel(10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
      for (int l = 0; l < 3; l++) begin
        total++;
        if (cd[l] !== exp_bits(S_C00, 10)) begin
          bad++;
          $display("FAIL ctrl_idle p%0d lane%0d: got %b expected %b", p, l, cd[l], exp_bits(S_C00, 10));
        end
      end
      total++;
      if (cc !== exp_clk(10)) begin
        bad++;
        $display("FAIL ctrl_idle_clk p%0d: got %b expected %b", p, cc, exp_clk(10));
      end
    end
  endtask

  task automatic test_sync();
    // {v_sync,h_sync} sent each frame; the frame after shows its symbol
    logic [1:0] c_tab [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [9:0] s_tab [5] = '{S_C00, S_C01, S_C10, S_C11, S_C00};
    for (int i = 0; i < 5; i++) begin
      pixel(10, 1'b1, c_tab[i][0], c_tab[i][1], 8'h00, 8'h00, 8'h00, cd, cc);
      total++;
      if (cd[0] !== exp_bits(s_tab[i], 10)) begin
        bad++;
        $display("FAIL sync_lane0 step%0d: got %b expected %b", i, cd[0], exp_bits(s_tab[i], 10));
      end
      for (int l = 1; l < 3; l++) begin
        total++;
        if (cd[l] !== exp_bits(S_C00, 10)) begin
          bad++;
          $display("FAIL sync_lane%0d step%0d: got %b expected %b", l, i, cd[l], exp_bits(S_C00, 10));
        end
      end
    end
  endtask

  task automatic test_dc_balance();
    // blue=00 (cnt 0,-8,2,-6,4), green=10 (n1q==n0q, cnt stays 0),
    // red=FF (cnt 0,-8,-2,4,-4)
    logic [9:0] exp_b [5] = '{S_C00, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
    logic [9:0] exp_g [5] = '{S_C00, 10'h1F0, 10'h1F0, 10'h1F0, 10'h1F0};
    logic [9:0] exp_r [5] = '{S_C00, 10'h200, 10'h0FF, 10'h0FF, 10'h200};
    for (int i = 0; i < 5; i++) begin
      pixel(10, (i == 4), 1'b0, 1'b0, 8'hFF, 8'h10, 8'h00, cd, cc);
      total++;
      if (cd[0] !== exp_bits(exp_b[i], 10)) begin
        bad++;
        $display("FAIL dc_blue p%0d: got %b expected %b", i, cd[0], exp_bits(exp_b[i], 10));
      end
      total++;
      if (cd[1] !== exp_bits(exp_g[i], 10)) begin
        bad++;
        $display("FAIL dc_green p%0d: got %b expected %b", i, cd[1], exp_bits(exp_g[i], 10));
      end
      total++;
      if (cd[2] !== exp_bits(exp_r[i], 10)) begin
        bad++;
        $display("FAIL dc_red p%0d: got %b expected %b", i, cd[2], exp_bits(exp_r[i], 10));
      end
    end
  endtask

  task automatic test_boundary();
    // blue=FF -> XNOR inverted 10'b1000000000; green=0F (n1=4,d0=1) XOR;
    // red=F0 (n1=4,d0=0) XNOR
    logic [9:0] exp_s [3] = '{10'h200, 10'h105, 10'h205};
    pixel(10, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'hFF, cd, cc);
    pixel(10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    for (int l = 0; l < 3; l++) begin
      total++;
      if (cd[l] !== exp_bits(exp_s[l], 10)) begin
        bad++;
        $display("FAIL boundary lane%0d: got %b expected %b", l, cd[l], exp_bits(exp_s[l], 10));
      end
    end
  endtask

  task automatic test_early_late();
    // Late frame (13 cycles): symbol then three zero bits
    pixel(13, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    for (int l = 0; l < 3; l++) begin
      total++;
      if (cd[l] !== exp_bits(S_C00, 13)) begin
        bad++;
        $display("FAIL late lane%0d: got %b expected %b", l, cd[l], exp_bits(S_C00, 13));
      end
    end
    total++;
    if (cc !== exp_clk(13)) begin
      bad++;
      $display("FAIL late_clk: got %b expected %b", cc, exp_clk(13));
    end
    // Early frame (7 cycles): h_sync symbol truncated after bit 6
    pixel(7, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    total++;
    if (cd[0] !== exp_bits(S_C01, 7)) begin
      bad++;
      $display("FAIL early lane0: got %b expected %b", cd[0], exp_bits(S_C01, 7));
    end
    total++;
    if (cd[2] !== exp_bits(S_C00, 7)) begin
      bad++;
      $display("FAIL early lane2: got %b expected %b", cd[2], exp_bits(S_C00, 7));
    end
    // Nominal frame after the early reload
    pixel(10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    total++;
    if (cd[0] !== exp_bits(S_C00, 10)) begin
      bad++;
      $display("FAIL after_early lane0: got %b expected %b", cd[0], exp_bits(S_C00, 10));
    end
    total++;
    if (cc !== exp_clk(10)) begin
      bad++;
      $display("FAIL after_early_clk: got %b expected %b", cc, exp_clk(10));
    end
  endtask

  task automatic test_rst_mid();
    // Drive cnt to -8 then 2, then a third blue=00 pixel (cnt -> -6)
    pixel(10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    pixel(10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    pixel_clk = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) pixel_clk = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (tmds_d !== 3'b000 || tmds_clk !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got d=%b clk=%b expected d=000 clk=0", tmds_d, tmds_clk);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (tmds_d !== 3'b000 || tmds_clk !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_hold c%0d: got d=%b clk=%b expected d=000 clk=0", k, tmds_d, tmds_clk);
      end
    end
    // First ld after reset emits the reset control symbol
    pixel(10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    for (int l = 0; l < 3; l++) begin
      total++;
      if (cd[l] !== exp_bits(S_C00, 10)) begin
        bad++;
        $display("FAIL rst_release lane%0d: got %b expected %b", l, cd[l], exp_bits(S_C00, 10));
      end
    end
    // Blue=00 encoded with cnt=0 gives 10'h100 (10'h3FF if cnt survived)
    pixel(10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cd, cc);
    for (int l = 0; l < 3; l++) begin
      total++;
      if (cd[l] !== exp_bits(10'h100, 10)) begin
        bad++;
        $display("FAIL rst_cnt lane%0d: got %b expected %b", l, cd[l], exp_bits(10'h100, 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_idle();
    test_sync();
    test_dc_balance();
    test_boundary();
    test_early_late();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
